// File: rtl/ghash_ctrl.sv
// ghash_ctrl: GHASH sequencer. Holds subkey H and the running accumulator X
// and drives one multiply per input block, X <- (X ^ B) * H, on a shared
// pipelined gf128_mul whose enable is tied high at integration.
// Only one multiply is ever in flight; the next block is accepted only after
// the product has returned.
//
// Optional feature: define GHASH_TIMEOUT_EN to build a product-wait watchdog
// (TIMEOUT cycles in MUL) that raises the sticky err_o and returns to IDLE.
// Without the macro no counter exists, err_o is 0 and MUL waits indefinitely.
//
// Handshakes: a block transfers on a rising clk edge where blk_valid_i and
// blk_ready_o are both high; a tag transfers on an edge where tag_valid_o and
// tag_ready_i are both high. The valid side holds its data stable until the
// transfer; ready never depends on valid.
//
// state_o is a debug view of the FSM state (0 IDLE, 1 LOAD, 2 MUL, 3 DONE).
module ghash_ctrl #(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] h_i,
  input  logic             blk_valid_i,
  output logic             blk_ready_o,
  input  logic [WIDTH-1:0] blk_i,
  input  logic             blk_last_i,
  output logic             tag_valid_o,
  input  logic             tag_ready_i,
  output logic [WIDTH-1:0] tag_o,
  output logic             busy_o,
  output logic             mul_valid_o,
  output logic [WIDTH-1:0] mul_a_o,
  output logic [WIDTH-1:0] mul_b_o,
  input  logic             mul_valid_i,
  input  logic [WIDTH-1:0] mul_result_i,
  output logic             err_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic             mul_valid_q, mul_valid_d;
  logic [WIDTH-1:0] tag_q, tag_d;
  logic             tag_valid_q, tag_valid_d;
  logic             timeout_w;

`ifdef GHASH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The wait expires on the MUL edge that would bring the count to TIMEOUT.
  assign timeout_w = (state_q == S_MUL) && !mul_valid_i &&
                     (cnt_q == CNT_W'(TIMEOUT - 1));

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Counter clears at issue and counts MUL cycles; error clears on a new hash.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_IDLE && start_i) begin
      err_d = 1'b0;
    end
    if (state_q == S_LOAD && blk_valid_i) begin
      cnt_d = '0;
    end
    if (state_q == S_MUL && !mul_valid_i) begin
      if (timeout_w) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign timeout_w = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_LOAD;
      S_LOAD: if (blk_valid_i) state_d = S_MUL;
      S_MUL: begin
        if (mul_valid_i) begin
          state_d = last_q ? S_DONE : S_LOAD;
        end else if (timeout_w) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: if (tag_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    blk_ready_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      S_IDLE:  busy_o      = 1'b0;
      S_LOAD:  blk_ready_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= '0;
      acc_q       <= '0;
      last_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_valid_q <= 1'b0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      acc_q       <= acc_d;
      last_q      <= last_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_valid_q <= mul_valid_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
    end
  end

  // Datapath updates; products are only taken in MUL, so stray or
  // post-reset replies never touch the accumulator.
  always_comb begin
    h_d         = h_q;
    acc_d       = acc_q;
    last_d      = last_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_valid_d = 1'b0;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          h_d   = h_i;
          acc_d = '0;
        end
      end
      S_LOAD: begin
        if (blk_valid_i) begin
          mul_a_d     = acc_q ^ blk_i;
          mul_b_d     = h_q;
          mul_valid_d = 1'b1;
          last_d      = blk_last_i;
        end
      end
      S_MUL: begin
        if (mul_valid_i) begin
          acc_d = mul_result_i;
          if (last_q) begin
            tag_d       = mul_result_i;
            tag_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (tag_ready_i) begin
          tag_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign mul_valid_o = mul_valid_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign tag_o       = tag_q;
  assign tag_valid_o = tag_valid_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ghash_ctrl.sv
// tb_ghash_ctrl: directed bench for ghash_ctrl with a behavioural GF(2^128)
// multiplier (GCM bit order) behind a variable-latency pipeline.
module tb_ghash_ctrl;

  localparam int W  = 128;
  localparam int TO = 16;
  localparam logic [127:0] H_KEY = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] BLK_C = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] BLK_L = 128'h00000000000000000000000000000080;
  localparam logic [127:0] TAG_2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start_i, blk_valid_i, blk_last_i, tag_ready_i;
  logic [W-1:0]  h_i, blk_i;
  logic          blk_ready_o, tag_valid_o, busy_o, mul_valid_o, err_o;
  logic [W-1:0]  tag_o, mul_a_o, mul_b_o;
  logic          mul_valid_i;
  logic [W-1:0]  mul_result_i;
  logic [1:0]    state_o;

  ghash_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .h_i(h_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_i(blk_i),
    .blk_last_i(blk_last_i), .tag_valid_o(tag_valid_o),
    .tag_ready_i(tag_ready_i), .tag_o(tag_o), .busy_o(busy_o),
    .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i), .err_o(err_o),
    .state_o(state_o)
  );

  // reference multiplier: SP 800-38D bit ordering, R = e1 || 0^120
  function automatic logic [127:0] gf_mul(input logic [127:0] x,
                                          input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  // multiplier pipeline, never reset (its enable is tied high)
  logic [15:0]  pv = '0;
  logic [127:0] pd [16];
  int           lat = 3;
  bit           mute = 1'b0;
  bit           spur = 1'b0;
  logic [127:0] spur_d = '0;
  always @(posedge clk) begin
    pv    <= {pv[14:0], mul_valid_o};
    pd[0] <= gf_mul(mul_a_o, mul_b_o);
    for (int k = 1; k < 16; k++) pd[k] <= pd[k-1];
  end
  assign mul_valid_i  = (pv[lat-1] & ~mute) | spur;
  assign mul_result_i = spur ? spur_d : pd[lat-1];

  // scoreboard counters
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_blk_ready"}, blk_ready_o, 0);
    check({tag, "_tag_valid"}, tag_valid_o, 0);
    check({tag, "_tag"},       tag_o, 0);
    check({tag, "_busy"},      busy_o, 0);
    check({tag, "_mul_valid"}, mul_valid_o, 0);
    check({tag, "_mul_a"},     mul_a_o, 0);
    check({tag, "_mul_b"},     mul_b_o, 0);
    check({tag, "_err"},       err_o, 0);
    check({tag, "_state"},     state_o, 0);
  endtask

  // driver tasks (all run on falling edges)
  task automatic start_hash(input logic [127:0] h);
    start_i = 1'b1;
    h_i     = h;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // returns the cycle count just after the handshake edge
  task automatic send_block(input logic [127:0] b, input bit last,
                            output int hs);
    int n;
    n = 0;
    blk_valid_i = 1'b1;
    blk_i       = b;
    blk_last_i  = last;
    while (blk_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("blk_ready_wait", 128'(n < 100), 1);
    @(negedge clk);
    hs          = cyc;
    blk_valid_i = 1'b0;
    blk_last_i  = 1'b0;
  endtask

  task automatic wait_ready(output int rc);
    int n;
    n = 0;
    while (blk_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_return_wait", 128'(n < 100), 1);
    rc = cyc;
  endtask

  task automatic wait_tag(output int tc);
    int n;
    n = 0;
    while (tag_valid_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tag_wait", 128'(n < 100), 1);
    tc = cyc;
  endtask

  task automatic take_tag();
    tag_ready_i = 1'b1;
    @(negedge clk);
    tag_ready_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, rc, tc;
    logic [127:0] x1;
    x1 = gf_mul(BLK_C, H_KEY);
    rst_n = 1'b0; start_i = 1'b0; h_i = '0; blk_valid_i = 1'b0;
    blk_i = '0; blk_last_i = 1'b0; tag_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single zero block, tag 0; tag visible L+1 edges after the handshake
    start_hash(H_KEY);
    check("t1_state_load", state_o, 1);
    check("t1_ready", blk_ready_o, 1);
    check("t1_busy", busy_o, 1);
    send_block('0, 1'b1, hs);
    check("t1_issue_pulse", mul_valid_o, 1);
    check("t1_mul_a", mul_a_o, 0);
    check("t1_mul_b", mul_b_o, H_KEY);
    check("t1_ready_in_mul", blk_ready_o, 0);
    @(negedge clk);
    check("t1_pulse_one_cycle", mul_valid_o, 0);
    wait_tag(tc);
    check("t1_tag_latency", 128'(tc - hs), 128'(lat + 1));
    check("t1_tag", tag_o, 0);
    take_tag();
    check("t1_idle_state", state_o, 0);
    check("t1_idle_tag_valid", tag_valid_o, 0);
    check("t1_idle_busy", busy_o, 0);

    // 2: two-block hash, throughput L+2, known tag
    start_hash(H_KEY);
    send_block(BLK_C, 1'b0, hs);
    check("t2_mul_a0", mul_a_o, BLK_C);
    wait_ready(rc);
    check("t2_throughput", 128'(rc - hs), 128'(lat + 1));
    send_block(BLK_L, 1'b1, hs);
    check("t2_mul_a1", mul_a_o, x1 ^ BLK_L);
    check("t2_mul_b1", mul_b_o, H_KEY);
    wait_tag(tc);
    check("t2_tag", tag_o, TAG_2);

    // 3: back-pressure in DONE with stray start/block pulses
    for (int i = 0; i < 5; i++) begin
      start_i     = (i == 1);
      blk_valid_i = (i == 3);
      @(negedge clk);
      start_i     = 1'b0;
      blk_valid_i = 1'b0;
      check("t3_tag_stable", tag_o, TAG_2);
      check("t3_tag_valid", tag_valid_o, 1);
      check("t3_ready_low", blk_ready_o, 0);
      check("t3_state_done", state_o, 3);
    end
    take_tag();
    check("t3_idle_after_hs", state_o, 0);
    start_hash(H_KEY);
    check("t3_restart_load", state_o, 1);

    // 4: slow multiplier (7 cycles) and spurious replies in LOAD
    lat = 7;
    spur = 1'b1; spur_d = 128'hdeadbeef_01234567_89abcdef_feedf00d;
    @(negedge clk);
    spur = 1'b0;
    check("t4_spur_no_move", state_o, 1);
    send_block(BLK_C, 1'b0, hs);
    wait_ready(rc);
    check("t4_throughput", 128'(rc - hs), 128'(lat + 1));
    spur = 1'b1; spur_d = 128'h0f0f0f0f_11111111_22222222_33333333;
    @(negedge clk);
    spur = 1'b0;
    check("t4_spur2_no_move", state_o, 1);
    send_block(BLK_L, 1'b1, hs);
    check("t4_mul_a1", mul_a_o, x1 ^ BLK_L);
    wait_tag(tc);
    check("t4_tag", tag_o, TAG_2);
    take_tag();

    // 5: asynchronous reset in MUL, late product afterwards
    start_hash(H_KEY);
    send_block(BLK_C, 1'b0, hs);
    repeat (2) @(negedge clk);
    check("t5_in_mul", state_o, 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_all_zero("t5_after_late");
    lat = 3;
    start_hash(H_KEY);
    send_block('0, 1'b1, hs);
    wait_tag(tc);
    check("t5_case1_latency", 128'(tc - hs), 128'(lat + 1));
    check("t5_case1_tag", tag_o, 0);
    take_tag();

`ifdef GHASH_TIMEOUT_EN
    // 6: multiplier never replies
    mute = 1'b1;
    start_hash(H_KEY);
    send_block(BLK_C, 1'b0, hs);
    repeat (15) @(negedge clk);
    check("t6_err_before", err_o, 0);
    check("t6_still_mul", state_o, 2);
    @(negedge clk);
    check("t6_err_set", err_o, 1);
    check("t6_idle", state_o, 0);
    check("t6_no_tag", tag_valid_o, 0);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", err_o, 1);
    mute = 1'b0;
    start_hash(H_KEY);
    check("t6_err_cleared", err_o, 0);
    check("t6_load", state_o, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
